// File: rtl/pipeline_pkg.sv
// Shared types for the Decode -> Execute boundary: control bundle, skid
// buffer states and the packed payload width.
package pipeline_pkg;

  typedef enum logic [1:0] {
    SRC_A_PC     = 2'd0,
    SRC_A_OLD_PC = 2'd1,
    SRC_A_RD1    = 2'd2,
    SRC_A_ZERO   = 2'd3
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRC_B_RD2  = 2'd0,
    SRC_B_IMM  = 2'd1,
    SRC_B_FOUR = 2'd2,
    SRC_B_RSVD = 2'd3
  } alu_src_b_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2,
    RES_IMM = 2'd3
  } result_src_t;

  typedef enum logic {
    ADR_PC     = 1'b0,
    ADR_RESULT = 1'b1
  } adr_src_t;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JALR   = 2'd2,
    PC_RSVD   = 2'd3
  } pc_src_t;

  typedef struct packed {
    alu_src_a_t  alu_src_a;
    alu_src_b_t  alu_src_b;
    result_src_t result_src;
    adr_src_t    adr_src;
    pc_src_t     pc_src;
    logic        pc_update;
    logic        branch;
    logic [3:0]  mem_write;
    logic [3:0]  mem_write_byte_address;
    logic        reg_write;
    logic [3:0]  alu_control;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } id_ex_ctrl_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int unsigned CTRL_W = $bits(id_ex_ctrl_t);

  // ctrl + rd1 + rd2 + imm + pc + rd_addr
  function automatic int unsigned payload_w(int unsigned xlen, int unsigned reg_addr_w);
    return CTRL_W + 4 * xlen + reg_addr_w;
  endfunction

  localparam int unsigned ID_EX_PAYLOAD_W = payload_w(32, 5);

endpackage

// File: rtl/skid_buffer.sv
// Generic valid/ready register stage. SKID_EN=1 gives a two-entry elastic
// buffer whose upstream ready comes straight from a flop; SKID_EN=0 is a
// single register with a combinational ready.
//
// state | meaning
// EMPTY | nothing held, out_valid_o=0
// HALF  | main register holds the entry presented downstream
// FULL  | main presented, skid holds the next entry, upstream stalled
module skid_buffer
  import pipeline_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  if (SKID_EN) begin : g_skid
    skid_state_t  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         ready_q;
    logic         xfer_in, xfer_out;

    assign xfer_in  = in_valid_i & ready_q;
    assign xfer_out = (state_q != EMPTY) & out_ready_i;

    // Next state and register loads; flush wins and leaves payload untouched.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY: begin
            if (xfer_in) begin
              state_d = HALF;
              main_d  = in_data_i;
            end
          end
          HALF: begin
            if (xfer_in && xfer_out) begin
              main_d = in_data_i;
            end else if (xfer_in) begin
              state_d = FULL;
              skid_d  = in_data_i;
            end else if (xfer_out) begin
              state_d = EMPTY;
            end
          end
          FULL: begin
            if (xfer_out) begin
              state_d = HALF;
              main_d  = skid_q;
            end
          end
          default: state_d = EMPTY;
        endcase
      end
    end

    // State, payload and the look-ahead ready flop.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_q <= EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        ready_q <= 1'b0;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        ready_q <= (state_d != FULL);
      end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = (state_q != EMPTY);
    assign out_data_o  = main_q;
  end else begin : g_single
    logic         valid_q;
    logic [W-1:0] data_q;
    logic         xfer_in;

    assign in_ready_o = ~valid_q | out_ready_i;
    assign xfer_in    = in_valid_i & in_ready_o;

    // Single holding register; accepted entries during flush are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else begin
        if (flush) begin
          valid_q <= 1'b0;
        end else if (xfer_in) begin
          valid_q <= 1'b1;
        end else if (valid_q && out_ready_i) begin
          valid_q <= 1'b0;
        end
        if (xfer_in && !flush) begin
          data_q <= in_data_i;
        end
      end
    end

    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// Decode -> Execute pipeline register: packs the decoded bundle into a skid
// buffer and counts cycles where Execute was ready but had nothing to do.
module id_ex_stage_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter bit          SKID_EN    = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  id_ex_ctrl_t           id_ctrl,
  input  logic [XLEN-1:0]       id_rd1,
  input  logic [XLEN-1:0]       id_rd2,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output id_ex_ctrl_t           ex_ctrl,
  output logic [XLEN-1:0]       ex_rd1,
  output logic [XLEN-1:0]       ex_rd2,
  output logic [XLEN-1:0]       ex_imm,
  output logic [XLEN-1:0]       ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic [CNT_W-1:0]      bubble_cnt
);

  localparam int unsigned PW = payload_w(XLEN, REG_ADDR_W);

  logic [PW-1:0]    in_payload;
  logic [PW-1:0]    out_payload;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  assign in_payload = {id_ctrl, id_rd1, id_rd2, id_imm, id_pc, id_rd_addr};
  assign {ex_ctrl, ex_rd1, ex_rd2, ex_imm, ex_pc, ex_rd_addr} = out_payload;

  skid_buffer #(
    .W       (PW),
    .SKID_EN (SKID_EN)
  ) u_skid (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid_i  (id_valid),
    .in_ready_o  (id_ready),
    .in_data_i   (in_payload),
    .out_valid_o (ex_valid),
    .out_ready_i (ex_ready),
    .out_data_o  (out_payload)
  );

  // Count idle Execute cycles, stop at all-ones, ignore redirect cycles.
  always_comb begin
    bubble_d = bubble_q;
    if (ex_ready && !ex_valid && !flush && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + CNT_W'(1);
    end
  end

  // Bubble counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_q <= '0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Bench for id_ex_stage_reg: three instances (skid/16-bit counter,
// skid/4-bit counter, single register) against an in-order FIFO model.
`timescale 1ns/1ps
module tb_id_ex_stage_reg;
  import pipeline_pkg::*;

  localparam int ND = 3;

  typedef struct packed {
    id_ex_ctrl_t ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  ra;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        flush_i[ND], id_valid_i[ND], ex_ready_i[ND];
  id_ex_ctrl_t ctrl_i[ND];
  logic [31:0] rd1_i[ND], rd2_i[ND], imm_i[ND], pc_i[ND];
  logic [4:0]  ra_i[ND];
  logic        id_ready_o[ND], ex_valid_o[ND];
  id_ex_ctrl_t ctrl_o[ND];
  logic [31:0] rd1_o[ND], rd2_o[ND], imm_o[ND], pc_o[ND];
  logic [4:0]  ra_o[ND];
  logic [15:0] bc_w[ND];

  for (genvar g = 0; g < ND; g++) begin : g_dut
    localparam int unsigned CW = (g == 1) ? 4 : 16;
    logic [CW-1:0] bc;
    id_ex_stage_reg #(
      .XLEN(32), .REG_ADDR_W(5), .SKID_EN(g != 2), .CNT_W(CW)
    ) dut (
      .clk(clk), .reset_n(reset_n), .flush(flush_i[g]),
      .id_valid(id_valid_i[g]), .id_ready(id_ready_o[g]),
      .id_ctrl(ctrl_i[g]), .id_rd1(rd1_i[g]), .id_rd2(rd2_i[g]),
      .id_imm(imm_i[g]), .id_pc(pc_i[g]), .id_rd_addr(ra_i[g]),
      .ex_valid(ex_valid_o[g]), .ex_ready(ex_ready_i[g]),
      .ex_ctrl(ctrl_o[g]), .ex_rd1(rd1_o[g]), .ex_rd2(rd2_o[g]),
      .ex_imm(imm_o[g]), .ex_pc(pc_o[g]), .ex_rd_addr(ra_o[g]),
      .bubble_cnt(bc)
    );
    assign bc_w[g] = 16'(bc);
  end

  // Reference model: an ordered list of held entries per instance.
  ent_t mbuf[ND][2];
  int   mcnt[ND];
  bit   mrdy[ND];
  int   mbc[ND];

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int maxbc(int d);
    return (d == 1) ? 15 : 65535;
  endfunction

  function automatic bit exp_ready(int d);
    if (d < 2) return mrdy[d];
    return (mcnt[d] == 0) || ex_ready_i[d];
  endfunction

  function automatic ent_t ent_in(int d);
    ent_t e;
    e.ctrl = ctrl_i[d]; e.rd1 = rd1_i[d]; e.rd2 = rd2_i[d];
    e.imm = imm_i[d]; e.pc = pc_i[d]; e.ra = ra_i[d];
    return e;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      mcnt[d] = 0; mrdy[d] = 1'b0; mbc[d] = 0;
    end
  endtask

  task automatic drive(input int d, input bit v, input logic [31:0] pc, input bit er, input bit fl);
    logic [63:0] r;
    r = {$urandom, $urandom};
    ctrl_i[d]     = id_ex_ctrl_t'(r[CTRL_W-1:0]);
    rd1_i[d]      = $urandom;
    rd2_i[d]      = $urandom;
    imm_i[d]      = $urandom;
    ra_i[d]       = 5'($urandom_range(0, 31));
    pc_i[d]       = pc;
    id_valid_i[d] = v;
    ex_ready_i[d] = er;
    flush_i[d]    = fl;
  endtask

  task automatic idle_all();
    for (int d = 0; d < ND; d++) drive(d, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic step();
    bit in_x[ND];
    bit out_x[ND];
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d ex_valid", d), 64'(ex_valid_o[d]), 64'(mcnt[d] != 0));
      check($sformatf("d%0d id_ready", d), 64'(id_ready_o[d]), 64'(exp_ready(d)));
      check($sformatf("d%0d bubble_cnt", d), 64'(bc_w[d]), 64'(mbc[d]));
      if (mcnt[d] != 0) begin
        check($sformatf("d%0d ex_pc", d), 64'(pc_o[d]), 64'(mbuf[d][0].pc));
        check($sformatf("d%0d ex_rd1", d), 64'(rd1_o[d]), 64'(mbuf[d][0].rd1));
        check($sformatf("d%0d ex_rd2", d), 64'(rd2_o[d]), 64'(mbuf[d][0].rd2));
        check($sformatf("d%0d ex_imm", d), 64'(imm_o[d]), 64'(mbuf[d][0].imm));
        check($sformatf("d%0d ex_rd_addr", d), 64'(ra_o[d]), 64'(mbuf[d][0].ra));
        check($sformatf("d%0d ex_ctrl", d), 64'(ctrl_o[d]), 64'(mbuf[d][0].ctrl));
      end
      in_x[d]  = reset_n && id_valid_i[d] && exp_ready(d);
      out_x[d] = reset_n && (mcnt[d] != 0) && ex_ready_i[d];
    end
    @(posedge clk);
    for (int d = 0; d < ND; d++) begin
      if (!reset_n) begin
        mcnt[d] = 0; mrdy[d] = 1'b0; mbc[d] = 0;
      end else begin
        if (ex_ready_i[d] && mcnt[d] == 0 && !flush_i[d] && mbc[d] < maxbc(d)) mbc[d]++;
        if (flush_i[d]) begin
          mcnt[d] = 0;
        end else begin
          if (out_x[d]) begin
            mbuf[d][0] = mbuf[d][1];
            mcnt[d]--;
          end
          if (in_x[d]) begin
            mbuf[d][mcnt[d]] = ent_in(d);
            mcnt[d]++;
          end
        end
        mrdy[d] = (mcnt[d] < 2);
      end
    end
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s d%0d ex_valid", tag, d), 64'(ex_valid_o[d]), 64'(0));
      if (d < 2) check($sformatf("%s d%0d id_ready", tag, d), 64'(id_ready_o[d]), 64'(0));
      check($sformatf("%s d%0d bubble", tag, d), 64'(bc_w[d]), 64'(0));
      check($sformatf("%s d%0d ex_pc", tag, d), 64'(pc_o[d]), 64'(0));
      check($sformatf("%s d%0d ex_rd1", tag, d), 64'(rd1_o[d]), 64'(0));
      check($sformatf("%s d%0d ex_rd2", tag, d), 64'(rd2_o[d]), 64'(0));
      check($sformatf("%s d%0d ex_imm", tag, d), 64'(imm_o[d]), 64'(0));
      check($sformatf("%s d%0d ex_rd_addr", tag, d), 64'(ra_o[d]), 64'(0));
      check($sformatf("%s d%0d ex_ctrl", tag, d), 64'(ctrl_o[d]), 64'(0));
    end
  endtask

  initial begin
    reset_n = 1'b0;
    idle_all();
    model_reset();
    @(posedge clk); #1;
    check_reset_outputs("por");
    step(); step();
    #2 reset_n = 1'b1;

    // Back-to-back stream 0x100..0x11C with Execute ready.
    drive(0, 1'b1, 32'h100, 1'b0, 1'b0);
    step();
    check("d0 ready after release", 64'(id_ready_o[0]), 64'(1));
    step();
    check("d0 first latency", 64'(pc_o[0]), 64'h100);
    for (int i = 1; i < 8; i++) begin
      drive(0, 1'b1, 32'h100 + 32'(4 * i), 1'b1, 1'b0);
      step();
      check("d0 stream pc", 64'(pc_o[0]), 64'(32'h100 + 32'(4 * i)));
      check("d0 stream valid", 64'(ex_valid_o[0]), 64'(1));
    end
    drive(0, 1'b0, 32'h0, 1'b1, 1'b0);
    step();
    check("d0 drained", 64'(ex_valid_o[0]), 64'(0));
    drive(0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("d0 stream bubbles", 64'(bc_w[0]), 64'(0));

    // Back-pressure: 0x200 held, 0x204 into skid, 0x208 stalled.
    drive(0, 1'b1, 32'h200, 1'b0, 1'b0); step();
    drive(0, 1'b1, 32'h204, 1'b0, 1'b0); step();
    check("d0 bp ready low", 64'(id_ready_o[0]), 64'(0));
    check("d0 bp hold pc", 64'(pc_o[0]), 64'h200);
    drive(0, 1'b1, 32'h208, 1'b0, 1'b0); step();
    check("d0 bp still hold", 64'(pc_o[0]), 64'h200);
    drive(0, 1'b1, 32'h208, 1'b1, 1'b0); step();
    check("d0 drain skid pc", 64'(pc_o[0]), 64'h204);
    check("d0 drain ready", 64'(id_ready_o[0]), 64'(1));
    drive(0, 1'b1, 32'h208, 1'b1, 1'b0); step();
    check("d0 drain last pc", 64'(pc_o[0]), 64'h208);
    drive(0, 1'b0, 32'h0, 1'b1, 1'b0); step();
    check("d0 bp empty", 64'(ex_valid_o[0]), 64'(0));

    // Flush while FULL with an incoming entry, then in HALF with accepted input.
    drive(0, 1'b1, 32'h300, 1'b0, 1'b0); step();
    drive(0, 1'b1, 32'h304, 1'b0, 1'b0); step();
    drive(0, 1'b1, 32'h308, 1'b0, 1'b1); step();
    check("d0 flush full valid", 64'(ex_valid_o[0]), 64'(0));
    check("d0 flush full ready", 64'(id_ready_o[0]), 64'(1));
    drive(0, 1'b1, 32'h400, 1'b0, 1'b0); step();
    drive(0, 1'b1, 32'h404, 1'b0, 1'b1); step();
    check("d0 flush half valid", 64'(ex_valid_o[0]), 64'(0));
    drive(0, 1'b0, 32'h0, 1'b1, 1'b0); step();
    check("d0 flushed never seen", 64'(ex_valid_o[0]), 64'(0));

    // Asynchronous reset between edges while FULL.
    drive(0, 1'b1, 32'h500, 1'b0, 1'b0); step();
    drive(0, 1'b1, 32'h504, 1'b0, 1'b0); step();
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("async");
    model_reset();
    idle_all();
    step(); step();
    #2 reset_n = 1'b1;

    // Saturation of the 4-bit counter.
    drive(1, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step();
    check("d1 bubble saturated", 64'(bc_w[1]), 64'd15);
    drive(1, 1'b0, 32'h0, 1'b0, 1'b0);

    // Single-register variant with ex_ready toggling 1,0,1.
    for (int i = 0; i < 12; i++) begin
      drive(2, 1'b1, 32'h600 + 32'(4 * i), (i % 3) != 1, 1'b0);
      #1;
      check("d2 comb ready", 64'(id_ready_o[2]), 64'((mcnt[2] == 0) || ex_ready_i[2]));
      step();
    end

    // Randomised traffic on all instances.
    for (int n = 0; n < 3000; n++) begin
      for (int d = 0; d < ND; d++) begin
        drive(d, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
